// File: rtl/mem_issue_sched.sv
// Round-robin issue of wavefront memory instructions onto the shared LSU port,
// throttled by per-wavefront and CU-wide in-flight operation counts.
module mem_issue_sched #(
  parameter int WF_PER_CU       = 40,
  parameter int WFID_W          = 6,
  parameter int PER_WF_MAX      = 7,
  parameter int CNT_W           = 3,
  parameter int MAX_OUTSTANDING = 8,
  parameter int GCNT_W          = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WF_PER_CU-1:0] mem_ready_arry,
  input  logic                 lsu_ready,
  input  logic                 lsu_done,
  input  logic [WFID_W-1:0]    lsu_done_wfid,
  output logic                 lsu_valid,
  output logic [WFID_W-1:0]    lsu_wfid,
  output logic [WF_PER_CU-1:0] mem_wait_arry,
  output logic [GCNT_W-1:0]    credits_avail,
  output logic                 sched_err
);

  localparam logic [WFID_W-1:0] LAST_WF  = WFID_W'(WF_PER_CU - 1);
  localparam logic [CNT_W-1:0]  CNT_CAP  = CNT_W'(PER_WF_MAX);
  localparam logic [GCNT_W-1:0] GCNT_CAP = GCNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]     cnt [WF_PER_CU];
  logic [GCNT_W-1:0]    gcnt;
  logic [WFID_W-1:0]    last_grant;

  logic [WF_PER_CU-1:0] elig;
  logic                 win_found;
  logic [WFID_W-1:0]    win_id;
  logic                 done_in_range;
  logic                 done_cnt_zero;
  logic                 retire_ok;
  logic                 retire_bad;
  logic [WF_PER_CU-1:0] issue_vec;
  logic [WF_PER_CU-1:0] retire_vec;

  always_comb begin
    elig          = '0;
    mem_wait_arry = '0;
    for (int i = 0; i < WF_PER_CU; i++) begin
      elig[i]          = mem_ready_arry[i] && (cnt[i] < CNT_CAP);
      mem_wait_arry[i] = (cnt[i] != '0);
    end
  end

  // Scan starts one past the last winner and wraps, so every wavefront gets a turn.
  always_comb begin
    int                idx;
    logic [WFID_W-1:0] sel;
    idx       = 0;
    sel       = '0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= WF_PER_CU; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= WF_PER_CU) idx = idx - WF_PER_CU;
      sel = WFID_W'(idx);
      if (!win_found && elig[sel]) begin
        win_found = 1'b1;
        win_id    = sel;
      end
    end
  end

  // The grant is suppressed while reset is held so the LSU never sees a phantom issue.
  assign lsu_valid     = !rst && lsu_ready && win_found && (gcnt < GCNT_CAP);
  assign lsu_wfid      = lsu_valid ? win_id : '0;
  assign credits_avail = GCNT_CAP - gcnt;

  always_comb begin
    done_in_range = (lsu_done_wfid <= LAST_WF);
    done_cnt_zero = 1'b0;
    for (int i = 0; i < WF_PER_CU; i++) begin
      if (WFID_W'(i) == lsu_done_wfid) done_cnt_zero = (cnt[i] == '0);
    end
    // A same-cycle issue to the retiring wavefront makes a zero count legal.
    retire_ok  = lsu_done && done_in_range &&
                 (!done_cnt_zero || (lsu_valid && (lsu_wfid == lsu_done_wfid)));
    retire_bad = lsu_done && !retire_ok;
    issue_vec  = '0;
    retire_vec = '0;
    for (int i = 0; i < WF_PER_CU; i++) begin
      issue_vec[i]  = lsu_valid && (lsu_wfid == WFID_W'(i));
      retire_vec[i] = retire_ok && (lsu_done_wfid == WFID_W'(i));
    end
  end

  // NOTE: the counter array is control state, not storage, so it is reset along
  // with everything else; sequential state is written only with non-blocking assigns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WF_PER_CU; i++) cnt[i] <= '0;
      gcnt       <= '0;
      last_grant <= LAST_WF;
      sched_err  <= 1'b0;
    end else begin
      if (lsu_valid)  last_grant <= lsu_wfid;
      if (retire_bad) sched_err  <= 1'b1;
      for (int i = 0; i < WF_PER_CU; i++) begin
        if (issue_vec[i] && !retire_vec[i])      cnt[i] <= cnt[i] + 1'b1;
        else if (retire_vec[i] && !issue_vec[i]) cnt[i] <= cnt[i] - 1'b1;
      end
      if (lsu_valid && !retire_ok)      gcnt <= gcnt + 1'b1;
      else if (retire_ok && !lsu_valid) gcnt <= gcnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_issue_sched.sv
// Directed bench for mem_issue_sched: expected grants go into a queue that a
// negedge monitor drains; state outputs are checked inline by the stimulus.
module tb_mem_issue_sched;

  localparam int WF_PER_CU = 40;
  localparam int WFID_W    = 6;
  localparam int GCNT_W    = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [WF_PER_CU-1:0] mem_ready_arry;
  logic                 lsu_ready;
  logic                 lsu_done;
  logic [WFID_W-1:0]    lsu_done_wfid;
  logic                 lsu_valid;
  logic [WFID_W-1:0]    lsu_wfid;
  logic [WF_PER_CU-1:0] mem_wait_arry;
  logic [GCNT_W-1:0]    credits_avail;
  logic                 sched_err;

  int checks = 0;
  int errors = 0;
  logic [WFID_W-1:0] exp_q[$];

  mem_issue_sched dut (
    .clk           (clk),
    .rst           (rst),
    .mem_ready_arry(mem_ready_arry),
    .lsu_ready     (lsu_ready),
    .lsu_done      (lsu_done),
    .lsu_done_wfid (lsu_done_wfid),
    .lsu_valid     (lsu_valid),
    .lsu_wfid      (lsu_wfid),
    .mem_wait_arry (mem_wait_arry),
    .credits_avail (credits_avail),
    .sched_err     (sched_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset applied between clock edges; outputs must clear at once.
  task automatic reset_pulse();
    #2 rst = 1'b1;
    #1;
    check("rst_valid",   64'(lsu_valid), 64'd0);
    check("rst_wfid",    64'(lsu_wfid), 64'd0);
    check("rst_wait",    64'(mem_wait_arry), 64'd0);
    check("rst_credits", 64'(credits_avail), 64'd8);
    check("rst_err",     64'(sched_err), 64'd0);
    @(posedge clk);
    #1;
    mem_ready_arry = '0;
    lsu_done       = 1'b0;
    rst            = 1'b0;
    #1;
    check("post_rst_credits", 64'(credits_avail), 64'd8);
  endtask

  // Monitor: pops an expected wavefront id for every grant the DUT presents.
  always @(negedge clk) begin
    if (!rst) begin
      if (lsu_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got wfid %0d expected no grant at %0t", lsu_wfid, $time);
        end else begin
          logic [WFID_W-1:0] e;
          e = exp_q.pop_front();
          check("grant_wfid", 64'(lsu_wfid), 64'(e));
        end
      end else begin
        check("idle_wfid_zero", 64'(lsu_wfid), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [WFID_W-1:0] seq [3];
    seq[0] = 6'd3; seq[1] = 6'd10; seq[2] = 6'd39;

    rst = 1'b1; mem_ready_arry = '0; lsu_ready = 1'b0; lsu_done = 1'b0; lsu_done_wfid = '0;
    step(); step();
    check("init_valid",   64'(lsu_valid), 64'd0);
    check("init_credits", 64'(credits_avail), 64'd8);
    rst = 1'b0;
    #1;
    check("init_wait", 64'(mem_wait_arry), 64'd0);
    check("init_err",  64'(sched_err), 64'd0);

    // Round-robin over {3,10,39}, with lsu_ready low for one cycle first.
    mem_ready_arry = '0;
    mem_ready_arry[3] = 1'b1; mem_ready_arry[10] = 1'b1; mem_ready_arry[39] = 1'b1;
    #1;
    check("noready_valid", 64'(lsu_valid), 64'd0);
    step();
    check("noready_credits", 64'(credits_avail), 64'd8);
    lsu_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(seq[k % 3]);
      lsu_done      = (k > 0);
      lsu_done_wfid = (k > 0) ? seq[(k + 2) % 3] : '0;
      step();
    end
    mem_ready_arry = '0;
    lsu_done = 1'b1; lsu_done_wfid = 6'd39;
    step();
    lsu_done = 1'b0;
    check("rr_credits", 64'(credits_avail), 64'd8);
    check("rr_wait",    64'(mem_wait_arry), 64'd0);
    check("rr_err",     64'(sched_err), 64'd0);
    check("rr_q_empty", 64'(exp_q.size()), 64'd0);

    // Per-wavefront cap: WF5 alone gets 7 grants, then stalls until a retire.
    mem_ready_arry = '0; mem_ready_arry[5] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      exp_q.push_back(6'd5);
      step();
    end
    check("cap_valid",   64'(lsu_valid), 64'd0);
    check("cap_wait5",   64'(mem_wait_arry[5]), 64'd1);
    check("cap_credits", 64'(credits_avail), 64'd1);
    lsu_done = 1'b1; lsu_done_wfid = 6'd5;
    #1;
    check("cap_retire_same_cycle_valid", 64'(lsu_valid), 64'd0);
    step();
    lsu_done = 1'b0;
    exp_q.push_back(6'd5);
    step();
    check("cap_regrant_credits", 64'(credits_avail), 64'd1);
    check("cap_q_empty", 64'(exp_q.size()), 64'd0);

    // Mid-stream reset with WF5 still ready and 7 ops in flight.
    reset_pulse();

    // Global credit limit: all WFs ready, WF0..7 granted, then stall.
    mem_ready_arry = '1;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(WFID_W'(k));
      step();
    end
    check("gcap_valid",   64'(lsu_valid), 64'd0);
    check("gcap_credits", 64'(credits_avail), 64'd0);
    lsu_done = 1'b1; lsu_done_wfid = 6'd2;
    #1;
    check("gcap_no_same_cycle_credit", 64'(lsu_valid), 64'd0);
    step();
    lsu_done = 1'b0;
    check("gcap_credit_back", 64'(credits_avail), 64'd1);
    exp_q.push_back(6'd8);
    step();
    mem_ready_arry = '0;
    #1;
    check("gcap_credits_after", 64'(credits_avail), 64'd0);
    check("gcap_wait", 64'(mem_wait_arry), 64'h1FB);
    check("gcap_q_empty", 64'(exp_q.size()), 64'd0);
    reset_pulse();

    // Same-cycle issue and retire on WF4 with two already in flight.
    mem_ready_arry = '0; mem_ready_arry[4] = 1'b1;
    exp_q.push_back(6'd4); step();
    exp_q.push_back(6'd4); step();
    check("same_pre_credits", 64'(credits_avail), 64'd6);
    exp_q.push_back(6'd4);
    lsu_done = 1'b1; lsu_done_wfid = 6'd4;
    step();
    mem_ready_arry = '0;
    lsu_done = 1'b0;
    check("same_credits", 64'(credits_avail), 64'd6);
    check("same_wait",    64'(mem_wait_arry), 64'h10);
    check("same_err",     64'(sched_err), 64'd0);
    lsu_done = 1'b1;
    step();
    check("same_drain1_credits", 64'(credits_avail), 64'd7);
    check("same_drain1_wait",    64'(mem_wait_arry), 64'h10);
    step();
    lsu_done = 1'b0;
    check("same_drain2_credits", 64'(credits_avail), 64'd8);
    check("same_drain2_wait",    64'(mem_wait_arry), 64'd0);
    check("same_drain_err",      64'(sched_err), 64'd0);

    // Protocol errors: retire to an idle WF, then an out-of-range id.
    mem_ready_arry = '0; mem_ready_arry[7] = 1'b1;
    exp_q.push_back(6'd7);
    step();
    mem_ready_arry = '0;
    lsu_done = 1'b1; lsu_done_wfid = 6'd12;
    step();
    lsu_done = 1'b0;
    check("err_idle_flag",    64'(sched_err), 64'd1);
    check("err_idle_credits", 64'(credits_avail), 64'd7);
    check("err_idle_wait",    64'(mem_wait_arry), 64'h80);
    lsu_done = 1'b1; lsu_done_wfid = 6'd45;
    step();
    lsu_done = 1'b0;
    check("err_range_flag",    64'(sched_err), 64'd1);
    check("err_range_credits", 64'(credits_avail), 64'd7);
    check("err_range_wait",    64'(mem_wait_arry), 64'h80);
    repeat (3) step();
    check("err_sticky", 64'(sched_err), 64'd1);
    reset_pulse();
    lsu_done = 1'b1; lsu_done_wfid = 6'd45;
    step();
    lsu_done = 1'b0;
    check("err_range_alone_flag",    64'(sched_err), 64'd1);
    check("err_range_alone_credits", 64'(credits_avail), 64'd8);
    check("final_q_empty", 64'(exp_q.size()), 64'd0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
